// File: rtl/norm_pkg.sv
// Shared constants and the controller state encoding for the norm accumulator feed path.
package norm_pkg;
    localparam int DATA_W  = 24;
    localparam int ACC_W   = 39;
    localparam int LEN_W   = 16;
    localparam int ACC_LAT = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/norm_beat_cnt.sv
// Loadable down-counter with a zero flag; used for both the beat count and the drain wait.
module norm_beat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load takes priority over decrement; decrementing stops at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/norm_feed_ctrl.sv
// Sequencer for the norm accumulator: clears it, feeds len operand pairs from the host
// stream, waits out the accumulator latency and captures the sum-of-squares result.
module norm_feed_ctrl #(
    parameter int DATA_W  = norm_pkg::DATA_W,
    parameter int ACC_W   = norm_pkg::ACC_W,
    parameter int LEN_W   = norm_pkg::LEN_W,
    parameter int ACC_LAT = norm_pkg::ACC_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    output logic [DATA_W-1:0] acc_x,
    output logic [DATA_W-1:0] acc_y,
    output logic              acc_en,
    output logic              acc_clr,
    input  logic [ACC_W-1:0]  acc_norm,
    output logic [ACC_W-1:0]  norm_out,
    output logic              busy,
    output logic              done
);

    import norm_pkg::*;

    state_t           state;
    logic             hs;
    logic             beat_load;
    logic             beat_dec;
    logic             beat_last;
    logic             beat_zero;
    logic [LEN_W-1:0] beat_count;
    logic             drain_load;
    logic             drain_dec;
    logic             drain_zero;
    logic [1:0]       drain_count_unused;

    // Pairs are accepted only while running; the last beat leaves RUN on the same edge.
    assign in_ready   = (state == S_RUN);
    assign hs         = in_valid && in_ready;
    assign beat_last  = (beat_count == LEN_W'(1));
    assign beat_load  = (state == S_IDLE) && start;
    assign beat_dec   = hs && !abort;
    // The drain wait is armed on every edge that enters DRAIN (from CLEAR or the last beat).
    assign drain_load = !abort && ((state == S_CLEAR) || (hs && beat_last));
    assign drain_dec  = (state == S_DRAIN) && !abort;

    norm_beat_cnt #(.W(LEN_W)) u_beat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (beat_load),
        .load_val (len),
        .dec      (beat_dec),
        .count    (beat_count),
        .zero     (beat_zero)
    );

    norm_beat_cnt #(.W(2)) u_drain_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (drain_load),
        .load_val (2'(ACC_LAT + 1)),
        .dec      (drain_dec),
        .count    (drain_count_unused),
        .zero     (drain_zero)
    );

    // Job FSM with registered strobes (acc_clr, acc_en, done), operand register and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc_en   <= 1'b0;
            acc_clr  <= 1'b0;
            acc_x    <= '0;
            acc_y    <= '0;
            norm_out <= '0;
        end else begin
            acc_en  <= 1'b0;
            acc_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_CLEAR;
                        busy    <= 1'b1;
                        acc_clr <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= beat_zero ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (hs) begin
                        acc_x  <= in_x;
                        acc_y  <= in_y;
                        acc_en <= 1'b1;
                        if (beat_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (drain_zero) begin
                        norm_out <= acc_norm;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_norm_feed_ctrl.sv
// Self-checking bench for norm_feed_ctrl with a behavioural accumulator (ACC_LAT=1).
module tb_norm_feed_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_x;
    logic [23:0] in_y;
    logic [23:0] acc_x;
    logic [23:0] acc_y;
    logic        acc_en;
    logic        acc_clr;
    logic [38:0] acc_norm;
    logic [38:0] norm_out;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int en_cnt   = 0;
    int done_cnt = 0;

    logic [23:0] px  [16];
    logic [23:0] py  [16];
    int          gap [16];
    logic [38:0] prev_norm = '0;

    norm_feed_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .acc_x    (acc_x),
        .acc_y    (acc_y),
        .acc_en   (acc_en),
        .acc_clr  (acc_clr),
        .acc_norm (acc_norm),
        .norm_out (norm_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Accumulator stand-in: one register stage, cleared by acc_clr.
    always @(posedge clk or posedge rst) begin
        if (rst)
            acc_norm <= '0;
        else if (acc_clr)
            acc_norm <= '0;
        else if (acc_en)
            acc_norm <= 39'(64'(acc_norm) + 64'(acc_x) * 64'(acc_x) + 64'(acc_y) * 64'(acc_y));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (acc_en) en_cnt++;
        if (done) done_cnt++;
    endtask

    // Runs one job over px/py/gap. abort_after>=0 aborts with that beat offered;
    // poke_at>=0 pulses start on that beat; abort_at_start raises abort with start.
    task automatic run_job(input int n, input int abort_after, input int poke_at,
                           input bit abort_at_start);
        logic [63:0] s;
        logic [38:0] exp;
        int waitc;
        int en0;
        int done0;
        s = '0;
        for (int i = 0; i < n; i++)
            s = s + 64'(px[i]) * 64'(px[i]) + 64'(py[i]) * 64'(py[i]);
        exp   = s[38:0];
        en0   = en_cnt;
        done0 = done_cnt;

        start = 1'b1;
        len   = 16'(n);
        abort = abort_at_start;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("clr_pulse", acc_clr, 1);
        chk("busy_in_clear", busy, 1);
        step();
        chk("clr_one_cycle", acc_clr, 0);

        for (int i = 0; i < n; i++) begin
            if (i == abort_after) begin
                in_valid = 1'b1;
                in_x = px[i];
                in_y = py[i];
                abort = 1'b1;
                step();
                abort = 1'b0;
                in_valid = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_no_en", acc_en, 0);
                chk("abort_ready", in_ready, 0);
                repeat (6) step();
                chk("abort_no_done", 64'(done_cnt - done0), 0);
                chk("abort_en_count", 64'(en_cnt - en0), 64'(abort_after));
                chk("abort_norm_hold", norm_out, prev_norm);
                return;
            end
            in_valid = 1'b0;
            for (int g = 0; g < gap[i]; g++) begin
                step();
                chk("gap_no_en", acc_en, 0);
            end
            in_valid = 1'b1;
            in_x  = px[i];
            in_y  = py[i];
            start = (i == poke_at);
            len   = 16'd9;
            chk("ready_in_run", in_ready, 1);
            step();
            start = 1'b0;
            chk("beat_en", acc_en, 1);
            chk("beat_x", acc_x, px[i]);
            chk("beat_y", acc_y, py[i]);
        end
        in_valid = 1'b0;
        chk("ready_low_after_last", in_ready, 0);
        waitc = 0;
        while (!done && waitc < 20) begin
            step();
            waitc++;
        end
        chk("done_latency", 64'(waitc), 3);
        chk("norm_out", norm_out, exp);
        chk("en_count", 64'(en_cnt - en0), 64'(n));
        chk("busy_in_done", busy, 1);
        step();
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
        chk("done_count", 64'(done_cnt - done0), 1);
        prev_norm = exp;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", acc_en, 0);
        chk("rst_clr", acc_clr, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_norm", norm_out, 0);
        chk("rst_acc_x", acc_x, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // single beat (3,4) after one idle RUN cycle
        px[0] = 24'd3; py[0] = 24'd4; gap[0] = 1;
        run_job(1, -1, -1, 1'b0);

        // zero length
        run_job(0, -1, -1, 1'b0);
        chk("zero_len_norm", norm_out, 0);

        // stalled stream
        px[0] = 24'd1; py[0] = 24'd2; gap[0] = 0;
        px[1] = 24'd2; py[1] = 24'd2; gap[1] = 2;
        px[2] = 24'd0; py[2] = 24'd3; gap[2] = 5;
        run_job(3, -1, -1, 1'b0);
        chk("stall_norm_22", norm_out, 22);

        // abort after two beats
        for (int i = 0; i < 4; i++) begin
            px[i] = 24'(5 + i); py[i] = 24'(5 + i); gap[i] = 0;
        end
        run_job(4, 2, -1, 1'b0);

        // following job proves the clear
        px[0] = 24'd3; py[0] = 24'd4; gap[0] = 0;
        run_job(1, -1, -1, 1'b0);
        chk("after_abort_25", norm_out, 25);

        // start ignored mid-run; start wins over abort in IDLE
        px[0] = 24'd7; py[0] = 24'd1; gap[0] = 1;
        px[1] = 24'd2; py[1] = 24'd9; gap[1] = 0;
        px[2] = 24'd4; py[2] = 24'd4; gap[2] = 2;
        run_job(3, -1, 1, 1'b1);

        // randomized jobs including full-width operands
        for (int j = 0; j < 8; j++) begin
            int n;
            n = int'($urandom_range(0, 6));
            for (int i = 0; i < n; i++) begin
                px[i]  = 24'($urandom);
                py[i]  = 24'($urandom);
                gap[i] = int'($urandom_range(0, 3));
            end
            run_job(n, -1, -1, 1'b0);
        end

        // reset asserted in DRAIN
        begin
            int done0;
            done0 = done_cnt;
            start = 1'b1;
            len   = 16'd2;
            step();
            start = 1'b0;
            step();
            in_valid = 1'b1;
            in_x = 24'd11;
            in_y = 24'd12;
            step();
            step();
            in_valid = 1'b0;
            chk("pre_rst_ready", in_ready, 0);
            #2;
            rst = 1'b1;
            #1;
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_done", done, 0);
            chk("mid_rst_en", acc_en, 0);
            chk("mid_rst_clr", acc_clr, 0);
            chk("mid_rst_norm", norm_out, 0);
            chk("mid_rst_acc_x", acc_x, 0);
            chk("mid_rst_acc_y", acc_y, 0);
            chk("mid_rst_ready", in_ready, 0);
            step();
            rst = 1'b0;
            repeat (6) step();
            chk("rst_no_done", 64'(done_cnt - done0), 0);
            chk("rst_idle_busy", busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
